// File: rtl/shift_reg_tap_ctrl.sv
// Address sequencer and tap scheduler for a RAM-based shift register.
// Drives a read-before-write BSRAM and flags which outputs are real D-delayed samples.
module shift_reg_tap_ctrl #(
    parameter int ASIZE   = 4,
    parameter int DEF_SEL = 4,
    parameter int LAT     = 1
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             ce,
    input  logic             flush,
    input  logic             depth_valid,
    input  logic [ASIZE-1:0] depth_sel,
    output logic             depth_ready,
    output logic [ASIZE-1:0] wr_addr,
    output logic [ASIZE-1:0] rd_addr,
    output logic             wr_en,
    output logic             rd_en,
    output logic [ASIZE-1:0] active_sel,
    output logic             q_valid
);

    localparam int              CW   = ASIZE + 1;
    localparam logic [CW-1:0]   FULL = CW'(2 ** ASIZE);
    localparam logic [ASIZE-1:0] DEF = ASIZE'(DEF_SEL);

    // EMPTY: cnt=0 | FILLING: 0<cnt<D | RUN: cnt>=D
    typedef enum logic [1:0] {EMPTY, FILLING, RUN} fill_t;

    logic [ASIZE-1:0] wptr;
    logic [ASIZE-1:0] pend_sel;
    logic             pend;
    logic [CW-1:0]    cnt;
    fill_t            state;
    logic [LAT-1:0]   rv_pipe;

    logic             xfer;
    logic             apply;
    logic             rv;
    logic [ASIZE-1:0] sel_nxt;
    logic [CW-1:0]    cnt_nxt;

    function automatic fill_t classify(input logic [CW-1:0] c, input logic [ASIZE-1:0] s);
        if (c == '0)
            return EMPTY;
        else if (c >= CW'(s) + CW'(1))
            return RUN;
        else
            return FILLING;
    endfunction

    assign wr_addr     = wptr;
    assign rd_addr     = wptr - active_sel - ASIZE'(1);
    assign wr_en       = ce;
    assign rd_en       = ce;
    assign depth_ready = !pend;
    assign q_valid     = rv_pipe[LAT-1];

    always_comb begin
        xfer    = depth_valid && !pend;
        apply   = pend && ce;
        sel_nxt = apply ? pend_sel : active_sel;
        // A flush coincident with a write keeps that write in the count.
        if (flush)
            cnt_nxt = CW'(ce);
        else if (ce && cnt != FULL)
            cnt_nxt = cnt + CW'(1);
        else
            cnt_nxt = cnt;
        // RUN tracks cnt >= active_sel+1 exactly, so it stands in for the compare.
        rv = ce && !flush && (state == RUN);
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wptr       <= '0;
            active_sel <= DEF;
            pend_sel   <= '0;
            pend       <= 1'b0;
            cnt        <= '0;
            state      <= EMPTY;
            rv_pipe    <= '0;
        end else begin
            if (ce)
                wptr <= wptr + ASIZE'(1);
            if (xfer) begin
                pend     <= 1'b1;
                pend_sel <= depth_sel;
            end else if (apply) begin
                pend <= 1'b0;
            end
            active_sel <= sel_nxt;
            cnt        <= cnt_nxt;
            state      <= classify(cnt_nxt, sel_nxt);
            rv_pipe    <= LAT'({rv_pipe, rv});
        end
    end

endmodule

// File: tb/tb_shift_reg_tap_ctrl.sv
// Randomized and directed bench for shift_reg_tap_ctrl with a write-count reference
// model and a read-before-write RAM driven by the DUT's own addresses.
module tb_shift_reg_tap_ctrl;

    localparam int ASIZE   = 4;
    localparam int DEF_SEL = 4;
    localparam int LAT     = 1;
    localparam int DEPTH   = 2 ** ASIZE;

    logic             clk = 1'b0;
    logic             Reset = 1'b1;
    logic             ce = 1'b0;
    logic             flush = 1'b0;
    logic             depth_valid = 1'b0;
    logic [ASIZE-1:0] depth_sel = '0;
    logic             depth_ready;
    logic [ASIZE-1:0] wr_addr;
    logic [ASIZE-1:0] rd_addr;
    logic             wr_en;
    logic             rd_en;
    logic [ASIZE-1:0] active_sel;
    logic             q_valid;

    logic [15:0] din = '0;
    logic [15:0] mem [DEPTH];
    logic [15:0] q_pipe [LAT];
    logic [15:0] q_data;

    int tests = 0;
    int fails = 0;

    // Reference model: writes counted since reset, fill window start, applied/pending depth.
    int n_wr, epoch, m_sel, m_pend_sel;
    bit m_pend;
    bit qv_pipe [LAT];
    int qd_pipe [LAT];

    shift_reg_tap_ctrl #(.ASIZE(ASIZE), .DEF_SEL(DEF_SEL), .LAT(LAT)) dut (
        .clk(clk), .Reset(Reset), .ce(ce), .flush(flush),
        .depth_valid(depth_valid), .depth_sel(depth_sel), .depth_ready(depth_ready),
        .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_en(wr_en), .rd_en(rd_en),
        .active_sel(active_sel), .q_valid(q_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en)
            q_pipe[0] <= mem[rd_addr];
        for (int i = 1; i < LAT; i++)
            q_pipe[i] <= q_pipe[i-1];
        if (wr_en)
            mem[wr_addr] <= din;
    end
    assign q_data = q_pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        n_wr = 0; epoch = 0; m_sel = DEF_SEL; m_pend = 0; m_pend_sel = 0;
        for (int i = 0; i < LAT; i++) begin
            qv_pipe[i] = 0;
            qd_pipe[i] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        Reset = 1'b1; ce = 1'b0; flush = 1'b0; depth_valid = 1'b0;
        #1;
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_rd_addr", rd_addr, 11);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_depth_ready", depth_ready, 1);
        chk("rst_active_sel", active_sel, DEF_SEL);
        chk("rst_q_valid", q_valid, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        Reset = 1'b0;
    endtask

    task automatic step(input bit c, input bit f, input bit dv, input logic [ASIZE-1:0] ds);
        bit rv;
        @(negedge clk);
        ce = c; flush = f; depth_valid = dv; depth_sel = ds; din = 16'(n_wr);
        #1;
        chk("wr_addr", wr_addr, 32'(n_wr & (DEPTH - 1)));
        chk("rd_addr", rd_addr, 32'((n_wr - m_sel - 1) & (DEPTH - 1)));
        chk("wr_en", wr_en, 32'(c));
        chk("rd_en", rd_en, 32'(c));
        chk("depth_ready", depth_ready, 32'(!m_pend));
        chk("active_sel", active_sel, 32'(m_sel));
        chk("q_valid", q_valid, 32'(qv_pipe[LAT-1]));
        if (qv_pipe[LAT-1])
            chk("q_data", q_data, 32'(qd_pipe[LAT-1] & 16'hFFFF));
        @(posedge clk);
        rv = c && !f && ((n_wr - epoch) >= m_sel + 1);
        for (int i = LAT - 1; i > 0; i--) begin
            qv_pipe[i] = qv_pipe[i-1];
            qd_pipe[i] = qd_pipe[i-1];
        end
        qv_pipe[0] = rv;
        qd_pipe[0] = n_wr - (m_sel + 1);
        if (m_pend && c) begin
            m_sel  = m_pend_sel;
            m_pend = 0;
        end else if (dv && !m_pend) begin
            m_pend     = 1;
            m_pend_sel = int'(ds);
        end
        if (f)
            epoch = n_wr;
        if (c)
            n_wr++;
    endtask

    initial begin
        model_reset();
        do_reset();

        repeat (150) step(1, 0, 0, 0);
        step(1, 0, 1, 15);
        repeat (40) step(1, 0, 0, 0);

        do_reset();
        repeat (30) step(1, 0, 0, 0);

        for (int i = 0; i < 40; i++) step(i % 2 == 0, 0, 0, 0);

        repeat (10) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        repeat (20) step(1, 0, 0, 0);

        repeat (20) step(0, 0, 1, 9);
        repeat (20) step(1, 0, 0, 0);

        step(1, 0, 1, 0);
        repeat (20) step(1, 0, 0, 0);

        step(0, 1, 1, 3);
        repeat (20) step(1, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            if (i == 300)
                do_reset();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_reg_tap_ctrl.md
Name: shift_reg_tap_ctrl

Overview:
- Address sequencer and tap scheduler for the RAM-based shift register datapath. The datapath is a single-port-pair BSRAM in read-before-write mode.
- Keeps a circular write pointer, derives the read (tap) address from the active depth and tracks fill level. It also flags when the RAM output is a real delayed sample.
- Accepts runtime depth changes through a valid/ready handshake and supports a flush command. The datapath top instantiates this block between the input stage and the BSRAM.

Parameters:
- ASIZE, 4, RAM address width; buffer holds 2^ASIZE samples.
- DEF_SEL, 4, depth select loaded at reset; delay D = sel+1 (default D=5).
- LAT, 1, BSRAM read latency in clk cycles (1 or 2).

Ports:
- clk  in  1  system clock
- Reset  in  1  asynchronous active-high reset
- ce  in  1  shift enable; one sample written/read per clk with ce=1
- flush  in  1  pulse: mark buffer contents invalid
- depth_valid  in  1  depth change request
- depth_sel  in  ASIZE  requested select; delay D = depth_sel+1 (1..2^ASIZE)
- depth_ready  out  1  request can be accepted
- wr_addr  out  ASIZE  BSRAM write address
- rd_addr  out  ASIZE  BSRAM read address
- wr_en  out  1  BSRAM write enable
- rd_en  out  1  BSRAM read/clock enable
- active_sel  out  ASIZE  select currently applied
- q_valid  out  1  BSRAM output this cycle is a valid D-delayed sample

Behaviour:
- Interface: one clock clk; Reset asynchronous, active-high. All state is cleared on Reset, including mid-operation and mid-handshake.
- Reset values:
  - wptr=0, wr_addr=0, rd_addr=(0-(DEF_SEL+1)) mod 2^ASIZE.
  - wr_en=0, rd_en=0, active_sel=DEF_SEL, pending=0.
  - depth_ready=1, q_valid=0, fill count cnt=0.
- Addressing (combinational from registers):
  - wr_addr=wptr.
  - rd_addr=(wptr-(active_sel+1)) mod 2^ASIZE.
  - wr_en=rd_en=ce.
  - D=2^ASIZE gives rd_addr=wr_addr; read-before-write returns the old sample.
- Pointer: on clk with ce=1, wptr<=wptr+1, wrapping 2^ASIZE-1 -> 0. With ce=0 all addresses and counters hold.
- Fill count cnt: number of writes since Reset/flush, saturating at 2^ASIZE. It increments on every ce cycle.
- Read valid:
  - rv = ce && (cnt >= active_sel+1), evaluated with pre-increment cnt.
  - rv is delayed through exactly LAT register stages to give q_valid, aligned with BSRAM Q.
- Fill state machine, derived from cnt:
  - EMPTY (cnt=0).
  - FILLING (0<cnt<D).
  - RUN (cnt>=D).
  - Depth decrease keeps the block in RUN.
  - Depth increase moves to FILLING if cnt < new D; otherwise it stays in RUN. Older samples are already in RAM, so no refill is needed.
- Depth handshake:
  - Transfer occurs when depth_valid && depth_ready; depth_sel is captured into pending.
  - depth_ready=0 while pending is held.
  - Pending is applied on the first following clk with ce=1: active_sel<=pending, and depth_ready returns to 1 the next cycle.
  - Reads in the apply cycle still use the old active_sel; new addressing starts at the next ce cycle.
  - With ce=0 the request stays pending indefinitely.
- Flush:
  - On flush, cnt<=0; wptr is unaffected. The new rv for that cycle is 0.
  - In-flight q_valid pipeline stages drain normally.
  - flush coincident with ce: cnt<=1, so the sample written that cycle counts.
- Simultaneous flush and depth transfer: both are performed.

Test Plan:
- Reset, ce=1 constant, ramp data into the RAM:
  - q_valid first rises LAT cycles after the 6th ce cycle (k=5).
  - Thereafter Q = Din-5 every cycle.
- After 150 ce cycles, request depth_sel=15:
  - depth_ready drops for 1 cycle and active_sel=15.
  - q_valid stays 1 (cnt saturated at 16) and Q = Din-16 from the following sample.
- Reset pulse mid-run (100 ns):
  - All outputs return to reset values; active_sel=4.
  - q_valid reasserts after 5 writes.
- Toggle ce 1/0 alternately:
  - wptr advances only on ce cycles and wraps 15->0.
  - rd_addr = wptr-5 mod 16 throughout.
- flush pulse during RUN with D=5:
  - q_valid goes low LAT cycles later for exactly 5 ce cycles, then resumes with Q = Din-5.
- depth_valid held with ce=0 for 20 cycles:
  - active_sel is unchanged and depth_ready=0.
  - The change applies on the first ce=1 cycle.
